// File: rtl/i2c_slave_reg_ctrl.sv
// ============================================================================
// i2c_slave_reg_ctrl
// ----------------------------------------------------------------------------
// Transaction controller between an I2C slave byte engine and a small local
// register file. It gives the master an EEPROM-style view of the registers:
//   - the first byte written after an address match loads the register pointer
//   - later written bytes go to mem[ptr]; each one advances the pointer
//   - every byte the slave loads for a read also advances the pointer
//   - the pointer survives STOP / repeated START, so a random read is a
//     pointer write, then a restart, then a read
// A local user port can read and write the same register file. When both
// sides write the same register in the same cycle, the I2C write wins.
//
// Parameters
//   ADDR_W   register pointer width; the file holds 2**ADDR_W bytes
//   RST_VAL  reset value of every register
//   RO_MASK  bit n = 1 makes register n read-only from I2C
//
// Ports
//   clk_i            system clock
//   rst_n_i          synchronous active-low reset
//   s_hit_i          address-match pulse from the slave (after address ACK)
//   s_rw_i           R/W bit of the matched address (1 = master reads)
//   s_stop_i         STOP detected pulse
//   s_restart_i      repeated START detected pulse
//   s_rx_data_i      byte received from the master
//   s_rx_valid_i     s_rx_data_i valid pulse
//   s_tx_req_i       slave has loaded s_tx_data_o into its shifter
//   s_tx_data_o      next byte to transmit (registered copy of mem[ptr])
//   usr_we_i         user write strobe
//   usr_addr_i       user register address
//   usr_wdata_i      user write data
//   usr_rdata_o      mem[usr_addr_i], one cycle latency
//   usr_wr_drop_o    pulse: a user write was lost to an I2C write collision
//   reg_upd_o        pulse: a register was written from I2C
//   reg_upd_addr_o   address of that I2C write
//   ro_err_o         pulse: an I2C write to a read-only register was dropped
//   busy_o           high while a transaction is in progress
// ============================================================================
module i2c_slave_reg_ctrl #(
    parameter int unsigned              ADDR_W  = 4,
    parameter logic [7:0]               RST_VAL = 8'h00,
    parameter logic [(1<<ADDR_W)-1:0]   RO_MASK = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              s_hit_i,
    input  logic              s_rw_i,
    input  logic              s_stop_i,
    input  logic              s_restart_i,
    input  logic [7:0]        s_rx_data_i,
    input  logic              s_rx_valid_i,
    input  logic              s_tx_req_i,
    output logic [7:0]        s_tx_data_o,
    input  logic              usr_we_i,
    input  logic [ADDR_W-1:0] usr_addr_i,
    input  logic [7:0]        usr_wdata_i,
    output logic [7:0]        usr_rdata_o,
    output logic              usr_wr_drop_o,
    output logic              reg_upd_o,
    output logic [ADDR_W-1:0] reg_upd_addr_o,
    output logic              ro_err_o,
    output logic              busy_o
);

    localparam int unsigned       DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          mem_q [DEPTH];

    logic                busy_q;
    logic                reg_upd_q;
    logic [ADDR_W-1:0]   reg_upd_addr_q;
    logic                ro_err_q;
    logic                usr_wr_drop_q;
    logic [7:0]          s_tx_data_q;
    logic [7:0]          usr_rdata_q;

    // Per-cycle decode of this cycle's events
    logic                end_s;       // STOP or repeated START
    logic                i2c_we_s;    // I2C write to mem[ptr_q] this cycle
    logic                ro_hit_s;    // I2C write blocked by RO_MASK
    logic                usr_we_s;    // user write actually performed
    logic                usr_drop_s;  // user write lost to I2C collision

    assign end_s = s_stop_i | s_restart_i;

    // Next state, next pointer and write decode for the I2C side
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        i2c_we_s = 1'b0;
        ro_hit_s = 1'b0;
        if (s_hit_i) begin
            // A fresh address match restarts the sequence from any state
            // and outranks a coincident STOP.
            state_d = s_rw_i ? ST_RD : ST_PTR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_PTR: begin
                    if (s_rx_valid_i) begin
                        // Upper bits of the pointer byte are ignored.
                        ptr_d   = s_rx_data_i[ADDR_W-1:0];
                        state_d = end_s ? ST_IDLE : ST_WR;
                    end else begin
                        state_d = end_s ? ST_IDLE : ST_PTR;
                    end
                end
                ST_WR: begin
                    if (s_rx_valid_i) begin
                        // The byte is consumed before any coincident STOP.
                        if (RO_MASK[ptr_q]) begin
                            ro_hit_s = 1'b1;
                        end else begin
                            i2c_we_s = 1'b1;
                        end
                        ptr_d = ptr_q + PTR_ONE;
                    end else begin
                        ptr_d = ptr_q;
                    end
                    state_d = end_s ? ST_IDLE : ST_WR;
                end
                ST_RD: begin
                    if (s_tx_req_i) begin
                        ptr_d = ptr_q + PTR_ONE;
                    end else begin
                        ptr_d = ptr_q;
                    end
                    state_d = end_s ? ST_IDLE : ST_RD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // User-port write arbitration against the I2C write of the same cycle
    always_comb begin
        usr_we_s   = 1'b0;
        usr_drop_s = 1'b0;
        if (usr_we_i) begin
            if (i2c_we_s && (usr_addr_i == ptr_q)) begin
                usr_drop_s = 1'b1;
            end else begin
                usr_we_s = 1'b1;
            end
        end else begin
            usr_we_s   = 1'b0;
            usr_drop_s = 1'b0;
        end
    end

    // Transaction FSM, pointer and registered status pulses
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            busy_q         <= 1'b0;
            reg_upd_q      <= 1'b0;
            reg_upd_addr_q <= '0;
            ro_err_q       <= 1'b0;
            usr_wr_drop_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            // busy is registered from the next state so it matches state_q.
            busy_q         <= (state_d != ST_IDLE);
            reg_upd_q      <= i2c_we_s;
            reg_upd_addr_q <= i2c_we_s ? ptr_q : reg_upd_addr_q;
            ro_err_q       <= ro_hit_s;
            usr_wr_drop_q  <= usr_drop_s;
        end
    end

    // Register file writes plus registered read ports for both sides
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_q       <= '{default: RST_VAL};
            s_tx_data_q <= RST_VAL;
            usr_rdata_q <= RST_VAL;
        end else begin
            // Arbitration guarantees the two writes never hit the same entry.
            if (i2c_we_s) begin
                mem_q[ptr_q] <= s_rx_data_i;
            end
            if (usr_we_s) begin
                mem_q[usr_addr_i] <= usr_wdata_i;
            end
            // Refreshed every cycle so it follows pointer moves and writes
            // from either side one cycle later.
            s_tx_data_q <= mem_q[ptr_q];
            usr_rdata_q <= mem_q[usr_addr_i];
        end
    end

    assign s_tx_data_o    = s_tx_data_q;
    assign usr_rdata_o    = usr_rdata_q;
    assign usr_wr_drop_o  = usr_wr_drop_q;
    assign reg_upd_o      = reg_upd_q;
    assign reg_upd_addr_o = reg_upd_addr_q;
    assign ro_err_o       = ro_err_q;
    assign busy_o         = busy_q;

endmodule
